burst_mem_responder: RTL

- Responder (memory) end of the lowmem burst interface that the CPU cache drives as initiator.
- Accepts one-cycle read/write burst commands and streams data beats with a per-beat `ready` strobe.
- Backed by an internal word-wide synchronous RAM.
- Programmable first-beat latency and mid-burst stall bubbles, so it serves both as an on-chip block-RAM backend and as a DRAM-timing stand-in for cache verification.

---
 rtl/burst_mem_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/burst_mem_responder.sv
// burst_mem_responder
// Memory-side responder for the lowmem burst interface. A one-cycle read or
// write command starts a burst of up to 255 word beats against an internal
// synchronous RAM. The first beat arrives FIRST_LAT cycles after the command,
// and an optional one-cycle bubble follows every STALL_EVERY beats. Together
// these let the block mimic DRAM timing when used as a cache test backend.

module burst_mem_responder #(
    parameter int ADDR_WIDTH  = 14,
    parameter int FIRST_LAT   = 3,
    parameter int STALL_EVERY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        burst_en,
    input  logic [7:0]  burst_length,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BEAT  = 2'd2,
        STALL = 2'd3
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAT_LOAD = 4'(FIRST_LAT - 1);

    state_t state;
    state_t state_nx;

    // Burst context captured with the command.
    logic [ADDR_WIDTH-1:0] base;
    logic                  is_write;
    logic [7:0]            len;

    // cnt is the index of the current beat while in BEAT and of the next beat
    // while in WAIT or STALL, so base+cnt is always the word being worked on.
    logic [7:0]            cnt;
    logic [7:0]            scnt;
    logic [3:0]            lat;
    logic                  busy_r;

    logic                  accept;
    logic [7:0]            cmd_len;
    logic [ADDR_WIDTH-1:0] cmd_word;
    logic                  last_beat;
    logic                  stall_hit;

    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [31:0]           spo_p1;

    logic [31:0]           mem [0:DEPTH-1];

    // Address bits outside the word range carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a[31:ADDR_WIDTH+2], a[1:0]};

    // A command is only taken when fully idle; busy also covers the cycle
    // after the last beat, so a command there is dropped.
    assign accept    = (we | rd) && (state == IDLE) && !busy_r;
    assign cmd_word  = a[ADDR_WIDTH+1:2];
    assign cmd_len   = !burst_en ? 8'd1 :
                       (burst_length == 8'd0) ? 8'd1 : burst_length;
    assign last_beat = (cnt == len - 8'd1);
    assign stall_hit = (STALL_EVERY != 0) && ((int'(scnt) + 1) == STALL_EVERY);

    assign ready = (state == BEAT);
    assign busy  = busy_r;
    assign spo   = spo_p1;

    // Write beats land at the edge closing the beat; a beat cut short by
    // reset must not write.
    assign ram_we = (state == BEAT) && is_write && !rst;
    assign waddr  = base + ADDR_WIDTH'(cnt);

    // Next-state logic and read-issue decision. A read is issued in the
    // cycle before every read beat so spo is registered yet back-to-back.
    always_comb begin
        state_nx = state;
        ram_re   = 1'b0;
        raddr    = base + ADDR_WIDTH'(cnt);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (FIRST_LAT == 1) begin
                        state_nx = BEAT;
                        ram_re   = !we;
                        raddr    = cmd_word;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat == 4'd1) begin
                    state_nx = BEAT;
                    ram_re   = !is_write;
                end
            end
            BEAT: begin
                if (last_beat) begin
                    state_nx = IDLE;
                end else if (stall_hit) begin
                    state_nx = STALL;
                end else begin
                    state_nx = BEAT;
                    ram_re   = !is_write;
                    raddr    = base + ADDR_WIDTH'(cnt + 8'd1);
                end
            end
            STALL: begin
                state_nx = BEAT;
                ram_re   = !is_write;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy_r   <= 1'b0;
            base     <= '0;
            is_write <= 1'b0;
            len      <= 8'd0;
            cnt      <= 8'd0;
            scnt     <= 8'd0;
            lat      <= 4'd0;
        end else begin
            state  <= state_nx;
            busy_r <= (state != IDLE) || accept;
            if (accept) begin
                base     <= cmd_word;
                is_write <= we;
                len      <= cmd_len;
                lat      <= LAT_LOAD;
                cnt      <= 8'd0;
                scnt     <= 8'd0;
            end
            if (state == WAIT) begin
                lat <= lat - 4'd1;
            end
            if (state == BEAT) begin
                cnt  <= cnt + 8'd1;
                scnt <= stall_hit ? 8'd0 : scnt + 8'd1;
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[waddr] <= d;
        end
    end

    // ---- read stage p1: registered RAM output, held between read beats ----
    always_ff @(posedge clk) begin
        if (rst) begin
            spo_p1 <= 32'd0;
        end else if (ram_re) begin
            spo_p1 <= mem[raddr];
        end
    end

endmodule
